seven_seg_scan_controller: RTL and testbench

Time-multiplexing scheduler for the board's 8-digit seven-segment display. It owns the shared segment bus (seg_a..seg_g, dp) and the anode lines, and gives each digit its own time slot. A short blanking interval at the start of every slot suppresses ghosting. Digit data is written through a valid/ready port into shadow registers, then committed atomically at a frame boundary, so a multi-digit value never tears on screen. The block sits between any producer (counter, FSM, switch logic) and the display pins in the top-level.

---
 rtl/seven_seg_scan_controller.sv | 94 +++++++++
 tb/tb_seven_seg_scan_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: time-multiplexed 8-digit seven-segment driver with shadow/active digit buffers
module seven_seg_scan_controller #(
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [2:0] load_digit,
    input  logic [3:0] load_value,
    input  logic       load_dp,
    input  logic       commit,
    output logic       commit_pending,
    input  logic [7:0] digit_en,
    output logic       frame_start,
    output logic       seg_a,
    output logic       seg_b,
    output logic       seg_c,
    output logic       seg_d,
    output logic       seg_e,
    output logic       seg_f,
    output logic       seg_g,
    output logic       dp,
    output logic [7:0] anodes
);
    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [CW-1:0]   cnt;
    logic [2:0]      dig;
    logic [7:0][4:0] shadow;
    logic [7:0][4:0] active;
    logic [6:0]      seg;
    logic            show;
    logic            frame_end;
    logic            wr;

    assign load_ready = ~commit_pending;
    assign wr = load_valid && load_ready;
    assign frame_end = dig == 3'd7 && cnt == LAST;
    assign show = digit_en[dig] && cnt >= BLANK_C;
    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;

    // Slot timer: cnt walks through one dwell period, then the scan moves to the next digit
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            dig <= '0;
        end else begin
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            if (cnt == LAST) dig <= dig + 1'b1;
        end
    end

    // Shadow writes, commit request, and the atomic shadow-to-active copy at frame end
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow         <= '0;
            active         <= '0;
            commit_pending <= 1'b0;
        end else begin
            if (wr) shadow[load_digit] <= {load_value, load_dp};
            if (commit_pending && frame_end) begin
                active         <= shadow;
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Registered pin drivers; everything stays dark during blanking or on disabled digits
    always_ff @(posedge clk) begin
        if (reset) begin
            anodes      <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            anodes      <= show ? ~(8'd1 << dig) : 8'hFF;
            seg         <= show ? HEX[active[dig][4:1]] : 7'h7F;
            dp          <= ~(show && active[dig][0]);
            frame_start <= dig == 3'd0 && cnt == '0;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller: scoreboard bench for the seven-segment scan controller
module tb_seven_seg_scan_controller;
    localparam int DWELL = 8;
    localparam int BLANK = 2;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
        logic       pend;
    } exp_t;

    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [2:0] load_digit;
    logic [3:0] load_value;
    logic       load_dp;
    logic       commit;
    logic       commit_pending;
    logic [7:0] digit_en;
    logic       frame_start;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic       dp;
    logic [7:0] anodes;
    logic [6:0] seg_obs;

    int n_checks = 0;
    int n_errors = 0;

    int         m_cnt;
    int         m_dig;
    logic [4:0] m_shadow [8];
    logic [4:0] m_active [8];
    logic       m_pend;
    exp_t       sb [$];

    int         low_cnt [8];
    int         fs_cnt;
    logic [7:0] an_mask;
    logic [7:0] dp_mask;
    logic [6:0] seg_slot [8];

    assign seg_obs = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    seven_seg_scan_controller #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_digit(load_digit), .load_value(load_value), .load_dp(load_dp),
        .commit(commit), .commit_pending(commit_pending), .digit_en(digit_en),
        .frame_start(frame_start), .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c),
        .seg_d(seg_d), .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g), .dp(dp), .anodes(anodes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_trk();
        for (int i = 0; i < 8; i++) begin
            low_cnt[i] = 0;
            seg_slot[i] = 7'h7F;
        end
        fs_cnt = 0;
        an_mask = '0;
        dp_mask = '0;
    endtask

    task automatic step();
        exp_t e;
        logic show;
        if (reset) begin
            e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = 1'b0;
            m_cnt = 0; m_dig = 0; m_pend = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
        end else begin
            show = digit_en[m_dig] && m_cnt >= BLANK;
            e.an  = show ? ~(8'd1 << m_dig) : 8'hFF;
            e.seg = show ? HEX[m_active[m_dig][4:1]] : 7'h7F;
            e.dp  = show ? ~m_active[m_dig][0] : 1'b1;
            e.fs  = m_dig == 0 && m_cnt == 0;
            if (load_valid && !m_pend) m_shadow[load_digit] = {load_value, load_dp};
            if (m_pend && m_dig == 7 && m_cnt == DWELL - 1) begin
                for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                m_pend = 1'b0;
            end else if (commit && !m_pend) begin
                m_pend = 1'b1;
            end
            if (m_cnt == DWELL - 1) begin
                m_cnt = 0;
                m_dig = (m_dig + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
        e.pend = m_pend;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("anodes", anodes, e.an);
        check("seg", seg_obs, e.seg);
        check("dp", dp, e.dp);
        check("frame_start", frame_start, e.fs);
        check("commit_pending", commit_pending, e.pend);
        check("load_ready", load_ready, !e.pend);
        for (int i = 0; i < 8; i++) begin
            if (!anodes[i]) begin
                low_cnt[i]++;
                seg_slot[i] = seg_obs;
            end
        end
        fs_cnt += frame_start ? 1 : 0;
        an_mask |= ~anodes;
        if (!dp) dp_mask |= ~anodes;
    endtask

    task automatic wait_copy();
        for (int i = 0; i < 200 && commit_pending; i++) step();
        check("copy_done", commit_pending, 0);
    endtask

    task automatic write(input int d, input int v, input logic p);
        load_valid = 1'b1; load_digit = 3'(d); load_value = 4'(v); load_dp = p;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_digit = '0; load_value = '0;
        load_dp = 1'b0; commit = 1'b0; digit_en = 8'hFF;
        clear_trk();
        repeat (3) step();
        reset = 1'b0;

        clear_trk();
        repeat (64) step();
        for (int i = 0; i < 8; i++) check($sformatf("low_cnt%0d", i), low_cnt[i], 6);
        check("fs_count", fs_cnt, 1);

        for (int d = 0; d < 8; d++) write(d, d, d == 3);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("ready_low_after_commit", load_ready, 0);
        wait_copy();
        clear_trk();
        repeat (64) step();
        check("slot2_seg", seg_slot[2], 7'b0010010);
        check("dp_mask", dp_mask, 8'b0000_1000);
        check("fs_count2", fs_cnt, 1);

        write(0, 9, 1'b0);
        commit = 1'b1;
        step();
        load_valid = 1'b1; load_digit = 3'd0; load_value = 4'd5;
        step();
        commit = 1'b0; load_valid = 1'b0;
        check("ready_low_pending", load_ready, 0);
        wait_copy();
        clear_trk();
        repeat (64) step();
        check("no_second_copy", commit_pending, 0);
        check("slot0_seg", seg_slot[0], 7'b0000100);

        for (int i = 0; i < 100 && !(m_dig == 7 && m_cnt == DWELL - 1); i++) step();
        load_valid = 1'b1; load_digit = 3'd1; load_value = 4'hA; load_dp = 1'b0;
        commit = 1'b1;
        step();
        load_valid = 1'b0; commit = 1'b0;
        check("edge_commit_pending", commit_pending, 1);
        clear_trk();
        repeat (64) step();
        check("slot1_old", seg_slot[1], 7'b1001111);
        check("edge_copy_done", commit_pending, 0);
        clear_trk();
        repeat (64) step();
        check("slot1_new", seg_slot[1], 7'b0001000);

        digit_en = 8'b0000_0101;
        clear_trk();
        repeat (72) step();
        check("en_mask", an_mask, 8'b0000_0101);
        check("en_low0", low_cnt[0] >= 6, 1);
        check("en_low1", low_cnt[1], 0);

        digit_en = 8'hFF;
        write(4, 7, 1'b1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check("rst_pending", commit_pending, 0);
        check("rst_ready", load_ready, 1);
        clear_trk();
        repeat (64) step();
        check("rst_slot4", seg_slot[4], 7'b0000001);
        check("rst_slot0", seg_slot[0], 7'b0000001);
        check("rst_dp", dp_mask, 8'h00);
        check("rst_fs", fs_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
